// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported instruction/data memory between the
//             fetch (IF) and memory (DM) stages of the core. The arbiter
//             latches one request, holds it for WAIT_STATES extra cycles,
//             and then returns registered read data with a one-cycle ready
//             pulse. DM wins conflicts. A starvation counter forces an IF
//             grant after STARVE_LIMIT consecutive IF losses.
//  Options  : define MEM_ARB_PERF_EN to build the grant/conflict counters.
//             Without it, the perf_* ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_dm_grants,
    output logic [31:0]       perf_conflicts
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_RESP   = 2'd2;

    localparam logic [3:0] c_WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        r_starve_cnt;
    logic              r_owner_dm;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_ready;
    logic              r_dm_ready;

    logic w_grant_if;
    logic w_grant_dm;

    // Arbitration: DM wins unless fetch has already lost STARVE_LIMIT times in a row
    always_comb begin
        w_grant_if = if_req && (!dm_req || (r_starve_cnt == c_STARVE_MAX));
        w_grant_dm = dm_req && !w_grant_if;
    end

    // Single FSM: the grant latches the request, ACCESS counts down the wait states, and RESP pulses ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_S_IDLE;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_owner_dm   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_ready   <= 1'b0;
            r_dm_ready   <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_grant_if || w_grant_dm) begin
                        r_owner_dm <= w_grant_dm;
                        r_addr     <= w_grant_dm ? dm_addr : if_addr;
                        // Fetch never writes, so its grant leaves the store data as it was
                        if (w_grant_dm) begin
                            r_wdata <= dm_wdata;
                        end
                        r_we       <= w_grant_dm && dm_we;
                        r_wait_cnt <= c_WAIT_INIT;
                        r_state    <= c_S_ACCESS;
                        if (w_grant_if) begin
                            r_starve_cnt <= '0;
                        end else if (if_req && (r_starve_cnt != c_STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end
                end
                c_S_ACCESS: begin
                    if (r_wait_cnt == 4'd0) begin
                        if (!r_we) begin
                            if (r_owner_dm) begin
                                r_dm_rdata <= mem_rdata;
                            end else begin
                                r_if_rdata <= mem_rdata;
                            end
                        end
                        r_if_ready <= !r_owner_dm;
                        r_dm_ready <= r_owner_dm;
                        r_state    <= c_S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                c_S_RESP: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register, so an async reset kills an in-flight write at once
    always_comb begin
        mem_en = (r_state == c_S_ACCESS);
        mem_we = (r_state == c_S_ACCESS) && r_we;
        busy   = (r_state != c_S_IDLE);
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_dm;
    logic [31:0] r_perf_conf;

    // Wrapping grant and conflict counters, sampled only on IDLE arbitration edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_if   <= '0;
            r_perf_dm   <= '0;
            r_perf_conf <= '0;
        end else if (r_state == c_S_IDLE) begin
            if (w_grant_if) begin
                r_perf_if <= r_perf_if + 32'd1;
            end
            if (w_grant_dm) begin
                r_perf_dm <= r_perf_dm + 32'd1;
            end
            if (if_req && dm_req) begin
                r_perf_conf <= r_perf_conf + 32'd1;
            end
        end
    end

    assign perf_if_grants = r_perf_if;
    assign perf_dm_grants = r_perf_dm;
    assign perf_conflicts = r_perf_conf;
`else
    assign perf_if_grants = '0;
    assign perf_dm_grants = '0;
    assign perf_conflicts = '0;
`endif

endmodule
`default_nettype wire
